// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, syncs, blanking,
// data-enable, start-of-frame / end-of-line pulses and a wrapping frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_cnt_w_check
    $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_porch_check
    $fatal(1, "vga_timing_gen: porch and sync widths must be at least 1");
  end

  localparam logic [CNT_W-1:0] HLast    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActEnd  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActEnd  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncBeg = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncBeg = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic               de_q, de_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;

  // Counter advance; frame wrap is the only way into (0,0) that raises sof.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    if (en) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        if (vcount_q == VLast) begin
          vcount_d = '0;
          frame_d  = frame_q + FRAME_W'(1);
          sof_d    = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
      eol_d = (hcount_d == HLast);
    end
  end

  // Level flags decode the next-state counters so they line up with hcount/vcount.
  always_comb begin
    hblnk_d = (hcount_d >= HActEnd);
    vblnk_d = (vcount_d >= VActEnd);
    hsync_d = ((hcount_d >= HSyncBeg) && (hcount_d < HSyncEnd)) ~^ HSYNC_POL;
    vsync_d = ((vcount_d >= VSyncBeg) && (vcount_d < VSyncEnd)) ~^ VSYNC_POL;
    de_d    = !hblnk_d && !vblnk_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      frame_q  <= '0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b1;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign frame_cnt = frame_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign hblnk     = hblnk_q;
  assign vblnk     = vblnk_q;
  assign de        = de_q;
  assign sof       = sof_q;
  assign eol       = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, inverted-polarity and tiny raster instances share
// clock/reset/enable and are compared every cycle against a pixel-tick reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [10:0] hc [3];
  logic [10:0] vc [3];
  logic [7:0]  fc [3];
  logic        hs [3];
  logic        vs [3];
  logic        hb [3];
  logic        vb [3];
  logic        de_o [3];
  logic        sof_o [3];
  logic        eol_o [3];

  int unsigned passed = 0;
  int unsigned total  = 0;
  longint      ticks  = 0;  // en-qualified pixel steps since last reset
  bit          stepped = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]),
    .vsync(vs[0]), .hblnk(hb[0]), .vblnk(vb[0]), .de(de_o[0]), .sof(sof_o[0]),
    .eol(eol_o[0]), .frame_cnt(fc[0])
  );

  vga_timing_gen #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]),
    .vsync(vs[1]), .hblnk(hb[1]), .vblnk(vb[1]), .de(de_o[1]), .sof(sof_o[1]),
    .eol(eol_o[1]), .frame_cnt(fc[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(hc[2]), .vcount(vc[2]), .hsync(hs[2]),
    .vsync(vs[2]), .hblnk(hb[2]), .vblnk(vb[2]), .de(de_o[2]), .sof(sof_o[2]),
    .eol(eol_o[2]), .frame_cnt(fc[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference: raster position is just the pixel tick count folded by line/frame size.
  task automatic check_dut(input int i, input string tag, input int ha, input int hfp,
                           input int hsw, input int hbp, input int va, input int vfp,
                           input int vsw, input int vbp, input bit hpol, input bit vpol);
    longint ht, vt, h, v, f;
    bit hbl, vbl, hsr, vsr;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    h   = ticks % ht;
    v   = (ticks / ht) % vt;
    f   = (ticks / (ht * vt)) % 256;
    hbl = (h >= ha);
    vbl = (v >= va);
    hsr = (h >= ha + hfp) && (h < ha + hfp + hsw);
    vsr = (v >= va + vfp) && (v < va + vfp + vsw);
    check({tag, ".hcount"}, 32'(hc[i]), 32'(h));
    check({tag, ".vcount"}, 32'(vc[i]), 32'(v));
    check({tag, ".frame"}, 32'(fc[i]), 32'(f));
    check({tag, ".hblnk"}, 32'(hb[i]), 32'(hbl));
    check({tag, ".vblnk"}, 32'(vb[i]), 32'(vbl));
    check({tag, ".de"}, 32'(de_o[i]), 32'(!hbl && !vbl));
    check({tag, ".hsync"}, 32'(hs[i]), 32'(hpol ? hsr : !hsr));
    check({tag, ".vsync"}, 32'(vs[i]), 32'(vpol ? vsr : !vsr));
    check({tag, ".sof"}, 32'(sof_o[i]), 32'(stepped && (ticks % (ht * vt) == 0)));
    check({tag, ".eol"}, 32'(eol_o[i]), 32'(stepped && (h == ht - 1)));
  endtask

  task automatic check_all();
    check_dut(0, "def", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    check_dut(1, "inv", 800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0);
    check_dut(2, "sml", 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    stepped = rst_n && en;
    if (!rst_n) ticks = 0;
    else if (en) ticks++;
    #1 check_all();
  endtask

  initial begin
    bit reached;
    rst_n = 1'b1;
    en    = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_all();
    en = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Free run: several default lines, many tiny frames.
    for (int n = 0; n < 3300; n++) step();

    // Enable alternating every clock.
    for (int n = 0; n < 200; n++) begin
      en = ~en;
      step();
    end

    // Random enable; long enough for the tiny raster's frame counter to wrap.
    for (int n = 0; n < 16000; n++) begin
      en = ($urandom_range(3, 0) != 0);
      step();
    end

    // Asynchronous reset mid-line at default hcount 500.
    en = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 2200 && !reached; n++) begin
      step();
      reached = ((ticks % 1056) == 500);
    end
    check("midline.reached", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    ticks   = 0;
    stepped = 1'b0;
    #1 check_all();
    step();
    #3 rst_n = 1'b1;
    for (int n = 0; n < 40; n++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
